// File: rtl/spare_alloc_ctrl.sv
// spare_alloc_ctrl: greedy spare-PE allocator for the BISR weight-proxy path.
// Maps each faulty PE, lowest index first, to the lowest free healthy spare.
module spare_alloc_ctrl #(
  parameter  int NUM_PES     = 8,
  parameter  int NUM_SPARES  = 4,
  localparam int SPARE_IDX_W =
    (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_PES-1:0]             fault_map,
  input  logic [NUM_SPARES-1:0]          spare_fault,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic [NUM_PES-1:0]             remap_valid,
  output logic [NUM_PES*SPARE_IDX_W-1:0] remap_idx,
  output logic [NUM_SPARES-1:0]          spare_used
);

  localparam int PE_IDX_W =
    (NUM_PES > 1) ? $clog2(NUM_PES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NUM_PES-1:0]             pending_q, pending_d;
  logic [NUM_SPARES-1:0]          used_q, used_d;
  logic [NUM_PES-1:0]             valid_q, valid_d;
  logic [NUM_PES*SPARE_IDX_W-1:0] idx_q, idx_d;
  logic                           ovf_q, ovf_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;

  logic [PE_IDX_W-1:0]    p;
  logic [SPARE_IDX_W-1:0] s;

  // Priority pick: lowest pending PE and lowest free spare.
  always_comb begin
    p = '0;
    s = '0;
    for (int i = NUM_PES - 1; i >= 0; i--) begin
      if (pending_q[i]) p = PE_IDX_W'(i);
    end
    for (int j = NUM_SPARES - 1; j >= 0; j--) begin
      if (!used_q[j]) s = SPARE_IDX_W'(j);
    end
  end

  // Next-state and next-output logic of the allocation FSM.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    used_d    = used_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pending_d = fault_map;
          used_d    = spare_fault;
          valid_d   = '0;
          idx_d     = '0;
          ovf_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = ALLOC;
        end
      end
      ALLOC: begin
        if (pending_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (&used_q) begin
          ovf_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          valid_d[p]                     = 1'b1;
          idx_d[p*SPARE_IDX_W +: SPARE_IDX_W] = s;
          used_d[s]                      = 1'b1;
          pending_d[p]                   = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset wipes any partial remap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      used_q    <= '0;
      valid_q   <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      used_q    <= used_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign remap_valid = valid_q;
  assign remap_idx   = idx_q;
  assign spare_used  = used_q;

endmodule
